// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
//   DataW / CntW   : operand and step-counter widths
//   ZeroWord       : all-zero data word
//   DivCntMax      : number of shift-subtract steps per divide
//   div_state_e    : DivFree (idle), DivOn (iterating), DivEnd (result held)
package div_unit_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 6;
  localparam int unsigned AccW  = 2 * DataW + 1;

  localparam logic [DataW-1:0] ZeroWord  = '0;
  localparam logic [CntW-1:0]  DivCntMax = 6'd32;

  typedef enum logic [1:0] {
    DivFree = 2'd0,
    DivOn   = 2'd1,
    DivEnd  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for the EX stage (DIV/DIVU/REM/REMU).
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   start      : divide request, held by EX until ready
//   annul      : pipeline flush, forces idle (priority over start)
//   signed_div : 1 = DIV/REM, 0 = DIVU/REMU
//   is_rem     : 1 = return remainder, 0 = return quotient
//   opdata1    : dividend
//   opdata2    : divisor
//   result     : quotient or remainder, zero unless ready
//   ready      : result valid (DivEnd state)
//   busy       : iteration in progress (DivOn state)
module div_unit
  import div_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             annul,
  input  logic             signed_div,
  input  logic             is_rem,
  input  logic [DataW-1:0] opdata1,
  input  logic [DataW-1:0] opdata2,
  output logic [DataW-1:0] result,
  output logic             ready,
  output logic             busy
);

  div_state_e         r_state,   w_state_nxt;
  logic [CntW-1:0]    r_cnt,     w_cnt_nxt;
  // {partial remainder (33 bits), quotient / remaining dividend (32 bits)}
  logic [AccW-1:0]    r_acc,     w_acc_nxt;
  logic [DataW-1:0]   r_divisor, w_divisor_nxt;
  logic               r_neg_q,   w_neg_q_nxt;
  logic               r_neg_r,   w_neg_r_nxt;
  logic               r_is_rem,  w_is_rem_nxt;
  logic [DataW-1:0]   r_result,  w_result_nxt;

  logic [DataW-1:0]   w_abs1;
  logic [DataW-1:0]   w_abs2;
  logic [AccW-1:0]    w_shift;
  logic [DataW+1:0]   w_sub;
  logic [AccW-1:0]    w_step;
  logic [DataW-1:0]   w_quo_fin;
  logic [DataW-1:0]   w_rem_fin;

  // Magnitudes of the operands; unsigned mode passes them through untouched.
  assign w_abs1 = (signed_div && opdata1[DataW-1]) ? (ZeroWord - opdata1) : opdata1;
  assign w_abs2 = (signed_div && opdata2[DataW-1]) ? (ZeroWord - opdata2) : opdata2;

  // One restoring step: shift left, trial-subtract the divisor from the upper 33 bits.
  // The extra MSB of w_sub is the borrow; on borrow the shifted value is kept.
  assign w_shift = {r_acc[AccW-2:0], 1'b0};
  assign w_sub   = {1'b0, w_shift[AccW-1:DataW]} - {2'b00, r_divisor};
  assign w_step  = w_sub[DataW+1] ? w_shift
                                  : {w_sub[DataW:0], w_shift[DataW-1:1], 1'b1};

  // Sign fix-up applied to the last step's outcome. The 0x80000000 / -1 case
  // falls out naturally: magnitudes give 0x80000000 r 0 and no negation applies.
  assign w_quo_fin = r_neg_q ? (ZeroWord - w_step[DataW-1:0]) : w_step[DataW-1:0];
  assign w_rem_fin = r_neg_r ? (ZeroWord - w_step[2*DataW-1:DataW])
                             : w_step[2*DataW-1:DataW];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_divisor_nxt = r_divisor;
    w_neg_q_nxt   = r_neg_q;
    w_neg_r_nxt   = r_neg_r;
    w_is_rem_nxt  = r_is_rem;
    w_result_nxt  = r_result;

    if (annul) begin
      w_state_nxt = DivFree;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        DivFree: begin
          if (start) begin
            if (opdata2 == ZeroWord) begin
              w_state_nxt  = DivEnd;
              w_result_nxt = is_rem ? opdata1 : {DataW{1'b1}};
            end else begin
              w_state_nxt   = DivOn;
              w_cnt_nxt     = '0;
              w_acc_nxt     = {{(DataW+1){1'b0}}, w_abs1};
              w_divisor_nxt = w_abs2;
              w_neg_q_nxt   = signed_div && (opdata1[DataW-1] ^ opdata2[DataW-1]);
              w_neg_r_nxt   = signed_div && opdata1[DataW-1];
              w_is_rem_nxt  = is_rem;
            end
          end
        end
        DivOn: begin
          if (!start) begin
            w_state_nxt = DivFree;
          end else begin
            w_acc_nxt = w_step;
            w_cnt_nxt = r_cnt + 6'd1;
            // Final step goes straight to DivEnd so ready lands 33 cycles after start.
            if (r_cnt == DivCntMax - 6'd1) begin
              w_state_nxt  = DivEnd;
              w_result_nxt = r_is_rem ? w_rem_fin : w_quo_fin;
            end
          end
        end
        DivEnd: begin
          if (!start) begin
            w_state_nxt = DivFree;
          end
        end
        default: begin
          w_state_nxt = DivFree;
        end
      endcase
    end

    // Result register only carries a value while in DivEnd.
    if (w_state_nxt != DivEnd) begin
      w_result_nxt = ZeroWord;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DivFree;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_q   <= w_neg_q_nxt;
      r_neg_r   <= w_neg_r_nxt;
      r_is_rem  <= w_is_rem_nxt;
      r_result  <= w_result_nxt;
    end
  end

  assign result = r_result;
  assign ready  = (r_state == DivEnd);
  assign busy   = (r_state == DivOn);

endmodule
